operand_entry_fsm: RTL and testbench

- Upstream input stage for the 4-bit calculator datapath.
- Takes one 4-bit switch bank and one raw push-button.
- Synchronizes and debounces the button, then steps through entry of operand A, operand B and the operation select.
- Presents the three captured values as stable registered outputs that feed the calculator's a/b/sel inputs, with a valid level and a one-cycle go pulse.

---
 rtl/operand_entry_fsm.sv | 93 +++++++++
 tb/tb_operand_entry_fsm.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry_fsm.sv
// operand_entry_fsm: debounced single-button entry of operand A, operand B and op select
// for the 4-bit calculator, presented as registered a/b/sel with valid and a go pulse.
module operand_entry_fsm #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    input  logic         btn,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [N-1:0] sel,
    output logic         valid,
    output logic         go,
    output logic [1:0]   state
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    typedef enum logic [1:0] {LOAD_A = 2'd0, LOAD_B = 2'd1, LOAD_OP = 2'd2, SHOW = 2'd3} state_t;

    state_t         state_q, state_d;
    logic           btn_m_q, btn_s_q;
    logic [N-1:0]   sw_m_q, sw_s_q;
    logic           db_q, db_d, db_dly_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d, sel_q, sel_d;
    logic           valid_q, valid_d, go_q, go_d;
    logic           press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_m_q  <= 1'b0;
            btn_s_q  <= 1'b0;
            sw_m_q   <= '0;
            sw_s_q   <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            go_q     <= 1'b0;
        end else begin
            btn_m_q  <= btn;
            btn_s_q  <= btn_m_q;
            sw_m_q   <= sw;
            sw_s_q   <= sw_m_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            go_q     <= go_d;
        end
    end

    // A single matching sample clears the count, so only a sustained difference flips db.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (btn_s_q != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) db_d = btn_s_q;
            else cnt_d = cnt_q + CW'(1);
        end
    end

    assign press = db_q & ~db_dly_q;

    always_comb begin
        state_d = press ? state_t'(state_q + 2'd1) : state_q;
    end

    always_comb begin
        a_d     = (press && state_q == LOAD_A)  ? sw_s_q : a_q;
        b_d     = (press && state_q == LOAD_B)  ? sw_s_q : b_q;
        sel_d   = (press && state_q == LOAD_OP) ? sw_s_q : sel_q;
        valid_d = (state_d == SHOW);
        go_d    = press && (state_q == LOAD_OP);
    end

    assign a     = a_q;
    assign b     = b_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign go    = go_q;
    assign state = state_q;
endmodule

// File: tb/tb_operand_entry_fsm.sv
// tb_operand_entry_fsm: directed stimulus with a per-cycle reference model of the entry flow.
module tb_operand_entry_fsm;
    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0, rst = 1'b0, btn = 1'b0;
    logic [N-1:0] sw = '0;
    logic [N-1:0] a, b, sel;
    logic         valid, go;
    logic [1:0]   state;

    operand_entry_fsm #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn(btn),
        .a(a), .b(b), .sel(sel), .valid(valid), .go(go), .state(state)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    bit en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: button/switch delayed two samples; db flips once the last D synchronized
    // samples all disagree with it; each press advances a four-step entry cycle.
    logic [N-1:0] m_a, m_b, m_sel, m_sw1, m_sw;
    bit           m_s1, m_s, m_db, m_dbd, m_valid, m_go, pr;
    int           m_stage, k;
    bit           hist[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a = '0; m_b = '0; m_sel = '0; m_sw1 = '0; m_sw = '0;
            m_s1 = 0; m_s = 0; m_db = 0; m_dbd = 0; m_valid = 0; m_go = 0;
            m_stage = 0;
            hist.delete();
        end else begin
            pr = m_db && !m_dbd;
            m_go = pr && m_stage == 2;
            if (pr) begin
                if (m_stage == 0) m_a = m_sw;
                else if (m_stage == 1) m_b = m_sw;
                else if (m_stage == 2) m_sel = m_sw;
                m_stage = (m_stage + 1) % 4;
            end
            m_valid = (m_stage == 3);
            m_dbd = m_db;
            hist.push_back(m_s);
            if (hist.size() > D) void'(hist.pop_front());
            k = 0;
            foreach (hist[i]) if (hist[i] != m_db) k++;
            if (k == D) begin
                m_db = !m_db;
                hist.delete();
            end
            m_s = m_s1; m_s1 = btn;
            m_sw = m_sw1; m_sw1 = sw;
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("a", a, m_a);
            chk("b", b, m_b);
            chk("sel", sel, m_sel);
            chk("valid", valid, m_valid);
            chk("go", go, m_go);
            chk("state", state, m_stage);
        end
    end

    task automatic press(input logic [N-1:0] v);
        sw = v;
        btn = 1'b1;
        repeat (10) @(negedge clk);
        btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, a, 0);
        chk({tag, "_b"}, b, 0);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_go"}, go, 0);
        chk({tag, "_state"}, state, 0);
    endtask

    int gc, mx;
    logic [4:0] pat;

    initial begin
        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1 chk_zero("rst_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_state", state, 0);
        chk("idle_valid", valid, 0);

        // Full entry
        press(4'd3);
        chk("entry_a", a, 3);
        chk("entry_state1", state, 1);
        press(4'd5);
        chk("entry_b", b, 5);
        chk("entry_state2", state, 2);
        sw = 4'd4;
        btn = 1'b1;
        gc = 0;
        repeat (10) begin
            @(negedge clk);
            if (go) begin
                gc++;
                chk("go_in_show", state, 3);
            end
        end
        btn = 1'b0;
        repeat (10) @(negedge clk);
        chk("go_count", gc, 1);
        chk("entry_sel", sel, 4);
        chk("entry_state3", state, 3);
        chk("entry_valid", valid, 1);

        // Wrap out of SHOW keeps values, next press overwrites only a
        press(4'd9);
        chk("wrap_state", state, 0);
        chk("wrap_valid", valid, 0);
        chk("wrap_a", a, 3);
        chk("wrap_b", b, 5);
        chk("wrap_sel", sel, 4);
        press(4'd9);
        chk("wrap2_a", a, 9);
        chk("wrap2_b", b, 5);
        chk("wrap2_sel", sel, 4);

        // Latency: rise just before edge 0, capture at edge 6
        sw = 4'd7;
        btn = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            chk("lat_hold_state", state, 1);
            chk("lat_hold_b", b, 5);
        end
        @(negedge clk);
        chk("lat_state", state, 2);
        chk("lat_b", b, 7);
        btn = 1'b0;
        repeat (10) @(negedge clk);

        // Bounce rejection, then a long hold gives one advance
        pat = 5'b10101;
        mx = 0;
        for (int i = 4; i >= 0; i--) begin
            btn = pat[i];
            @(negedge clk);
            if (int'(dut.cnt_q) > mx) mx = int'(dut.cnt_q);
        end
        btn = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (int'(dut.cnt_q) > mx) mx = int'(dut.cnt_q);
        end
        chk("bounce_cnt_below3", (mx < 3), 1);
        chk("bounce_state", state, 2);
        btn = 1'b1;
        repeat (40) @(negedge clk);
        btn = 1'b0;
        repeat (10) @(negedge clk);
        chk("hold_state", state, 3);
        chk("hold_valid", valid, 1);

        // Reset mid-debounce in LOAD_OP, button held through release
        press(4'd0);
        press(4'd1);
        press(4'd2);
        chk("pre_rst_state", state, 2);
        sw = 4'd6;
        btn = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_cnt", dut.cnt_q, 2);
        #2 rst = 1'b1;
        #1 chk_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            chk("post_rst_a", a, 0);
            chk("post_rst_state", state, 0);
        end
        @(negedge clk);
        chk("post_rst_cap_a", a, 6);
        chk("post_rst_cap_state", state, 1);
        btn = 1'b0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
